// File: rtl/out_ctrl_sc2bin.sv
// rtl/out_ctrl_sc2bin.sv - stochastic bitstream to binary sample converter
//
// Counts the ones in a window of L = 2**W accepted stochastic bits and hands
// each completed count downstream over a valid/ready handshake. Windows run
// back to back once a start pulse has aligned the frame.
//
// Ports:
//   clock      - single clock, all state updates on posedge
//   reset_n    - asynchronous active-low reset
//   start      - frame sync pulse; the bit on this cycle is bit 1 of a new window
//   sc_bit     - stochastic bit from the FIR
//   sc_valid   - qualifies sc_bit
//   out        - ones count of the last completed window (0..L)
//   out_valid  - out holds an unconsumed sample
//   out_ready  - downstream accepts out when out_valid & out_ready
//   overrun    - sticky: a completed window was dropped because out was full
//   clr_ovr    - synchronous clear of overrun
module out_ctrl_sc2bin #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  input  logic         sc_bit,
  input  logic         sc_valid,
  output logic [W:0]   out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overrun,
  input  logic         clr_ovr
);

  localparam int unsigned LEN   = 1 << W;
  localparam logic [W:0]  L_CNT = LEN[W:0];
  localparam logic [W:0]  ONE   = {{W{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  state_t     state;
  logic [W:0] acc;
  logic [W:0] cnt;

  logic       accept;
  logic       done;
  logic       load;
  logic       drop;
  logic [W:0] acc_nxt;
  logic [W:0] cnt_nxt;

  // start overrides everything, including a coincident L-th bit, so an
  // accepted bit only advances the current window when start is low.
  assign accept  = (state == ACCUM) && sc_valid && !start;
  assign acc_nxt = acc + {{W{1'b0}}, sc_bit};
  assign cnt_nxt = cnt + ONE;
  assign done    = accept && (cnt_nxt == L_CNT);

  // A completed window lands in out if the slot is empty or being drained
  // on this very cycle; otherwise the result is lost and flagged.
  assign load    = done && (!out_valid || out_ready);
  assign drop    = done && out_valid && !out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (start) begin
        state <= ACCUM;
        acc   <= {{W{1'b0}}, sc_valid & sc_bit};
        cnt   <= {{W{1'b0}}, sc_valid};
      end else if (done) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end

      // out keeps its last value after being consumed; only out_valid drops.
      if (load) begin
        out       <= acc_nxt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
